// File: rtl/lfsr_pkg.sv
// Shared types and helpers for the LFSR random-number arbiter: FSM encoding,
// maximal-length tap/seed defaults and the one-step Fibonacci shift function.
package lfsr_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ADVANCE = 2'd1,
        GRANT   = 2'd2
    } fsm_state_t;

    localparam int LFSR_MAX_W = 32;

    // Maximal-length masks for the shift-left, feedback-into-bit-0 form.
    localparam logic [3:0]  TAPS_W4  = 4'b1100;
    localparam logic [3:0]  SEED_W4  = 4'hF;
    localparam logic [7:0]  TAPS_W8  = 8'hB8;
    localparam logic [7:0]  SEED_W8  = 8'hFF;
    localparam logic [15:0] TAPS_W16 = 16'hB400;
    localparam logic [15:0] SEED_W16 = 16'hFFFF;

    function automatic logic [LFSR_MAX_W-1:0] next_state(
        input logic [LFSR_MAX_W-1:0] state,
        input logic [LFSR_MAX_W-1:0] taps
    );
        return {state[LFSR_MAX_W-2:0], ^(state & taps)};
    endfunction

endpackage

// File: rtl/lfsr_rng_arbiter_core.sv
// Fibonacci LFSR with load/shift/hold controls. Defining LFSR_LOCKUP_DET_EN
// adds all-zero detection that reloads SEED and pulses lockup.
module lfsr_core
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 4,
    parameter logic [WIDTH-1:0] TAPS  = TAPS_W4,
    parameter logic [WIDTH-1:0] SEED  = SEED_W4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             shift,
    output logic [WIDTH-1:0] state,
    output logic [WIDTH-1:0] state_nxt,
    output logic             lockup
);

    logic [WIDTH-1:0] shifted;
    logic             zero_det;

    assign shifted = WIDTH'(next_state(LFSR_MAX_W'(state), LFSR_MAX_W'(TAPS)));

`ifdef LFSR_LOCKUP_DET_EN
    assign zero_det = (state == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lockup <= 1'b0;
        end else begin
            lockup <= zero_det;
        end
    end
`else
    assign zero_det = 1'b0;
    assign lockup   = 1'b0;
`endif

    // A zero seed would park the register in the dead state, so it maps to SEED.
    always_comb begin
        state_nxt = state;
        if (load) begin
            state_nxt = (load_val == '0) ? SEED : load_val;
        end else if (zero_det) begin
            state_nxt = SEED;
        end else if (shift) begin
            state_nxt = shifted;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SEED;
        end else begin
            state <= state_nxt;
        end
    end

endmodule

// File: rtl/lfsr_rng_arbiter.sv
// Round-robin arbiter handing fresh words from one shared LFSR to NUM_REQ
// requesters. Optional all-zero recovery is enabled by LFSR_LOCKUP_DET_EN.
module lfsr_rng_arbiter
    import lfsr_pkg::*;
#(
    parameter int               NUM_REQ = 4,
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] TAPS    = TAPS_W4,
    parameter logic [WIDTH-1:0] SEED    = SEED_W4,
    parameter int               STEPS   = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic [NUM_REQ-1:0]         req,
    output logic [NUM_REQ-1:0]         gnt,
    output logic                       rnd_valid,
    output logic [WIDTH-1:0]           rnd_data,
    output logic [$clog2(NUM_REQ)-1:0] gnt_id,
    input  logic                       seed_we,
    input  logic [WIDTH-1:0]           seed_data,
    output logic [WIDTH-1:0]           lfsr_state,
    output logic                       busy,
    output logic                       lockup
);

    localparam int                IDW      = $clog2(NUM_REQ);
    localparam int                CW       = 4;
    localparam logic [CW-1:0]     STEPS_M1 = CW'(STEPS - 1);
    localparam logic [IDW:0]      NREQ_W   = (IDW + 1)'(NUM_REQ);
    localparam logic [IDW-1:0]    LAST_ID  = IDW'(NUM_REQ - 1);

    generate
        if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
            $error("NUM_REQ must be in 2..8");
        end
        if (STEPS < 1 || STEPS > 15) begin : g_bad_steps
            $error("STEPS must be in 1..15");
        end
        if (WIDTH < 2 || WIDTH > LFSR_MAX_W) begin : g_bad_width
            $error("WIDTH must be in 2..32");
        end
        if (SEED == '0) begin : g_bad_seed
            $error("SEED must be nonzero");
        end
    endgenerate

    fsm_state_t         fsm, fsm_d;
    logic [IDW-1:0]     winner, winner_d;
    logic [IDW-1:0]     ptr, ptr_d;
    logic [CW-1:0]      cnt, cnt_d;
    logic [NUM_REQ-1:0] gnt_d;
    logic               vld_d;
    logic [WIDTH-1:0]   data_d;
    logic [IDW-1:0]     id_d;
    logic               busy_d;

    logic [NUM_REQ-1:0] arb_req;
    logic               arb_any;
    logic [IDW-1:0]     arb_win;
    logic               found;
    logic               lfsr_shift;
    logic [WIDTH-1:0]   lfsr_nxt;

    lfsr_core #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS),
        .SEED  (SEED)
    ) u_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (seed_we),
        .load_val  (seed_data),
        .shift     (lfsr_shift),
        .state     (lfsr_state),
        .state_nxt (lfsr_nxt),
        .lockup    (lockup)
    );

    // In GRANT the requester still holds req while seeing its own gnt, so mask it.
    always_comb begin
        arb_req = (fsm == GRANT) ? (req & ~gnt) : req;
        arb_any = |arb_req;
        arb_win = '0;
        found   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            logic [IDW:0] idx;
            idx = {1'b0, ptr} + (IDW + 1)'(i);
            if (idx >= NREQ_W) begin
                idx = idx - NREQ_W;
            end
            if (!found && arb_req[idx[IDW-1:0]]) begin
                arb_win = idx[IDW-1:0];
                found   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm <= IDLE;
        end else begin
            fsm <= fsm_d;
        end
    end

    always_comb begin
        fsm_d = fsm;
        case (fsm)
            IDLE: begin
                if (en && arb_any) begin
                    fsm_d = ADVANCE;
                end
            end
            ADVANCE: begin
                if (cnt == '0) begin
                    fsm_d = GRANT;
                end
            end
            GRANT: begin
                fsm_d = (en && arb_any) ? ADVANCE : IDLE;
            end
            default: fsm_d = IDLE;
        endcase
    end

    // Once a winner is latched the grant always completes; en only gates new arbitration.
    always_comb begin
        winner_d   = winner;
        ptr_d      = ptr;
        cnt_d      = cnt;
        gnt_d      = '0;
        vld_d      = 1'b0;
        data_d     = rnd_data;
        id_d       = gnt_id;
        lfsr_shift = 1'b0;
        case (fsm)
            IDLE, GRANT: begin
                if (en && arb_any) begin
                    winner_d = arb_win;
                    cnt_d    = STEPS_M1;
                end
            end
            ADVANCE: begin
                lfsr_shift = 1'b1;
                if (cnt != '0) begin
                    cnt_d = cnt - CW'(1);
                end else begin
                    gnt_d[winner] = 1'b1;
                    vld_d         = 1'b1;
                    data_d        = lfsr_nxt;
                    id_d          = winner;
                    ptr_d         = (winner == LAST_ID) ? '0 : winner + IDW'(1);
                end
            end
            default: ;
        endcase
        busy_d = (fsm_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            winner    <= '0;
            ptr       <= '0;
            cnt       <= '0;
            gnt       <= '0;
            rnd_valid <= 1'b0;
            rnd_data  <= '0;
            gnt_id    <= '0;
            busy      <= 1'b0;
        end else begin
            winner    <= winner_d;
            ptr       <= ptr_d;
            cnt       <= cnt_d;
            gnt       <= gnt_d;
            rnd_valid <= vld_d;
            rnd_data  <= data_d;
            gnt_id    <= id_d;
            busy      <= busy_d;
        end
    end

endmodule

// File: doc/lfsr_rng_arbiter.md
Name: lfsr_rng_arbiter

Overview:
- Shares one parameterised Fibonacci LFSR between NUM_REQ requesters, using round-robin arbitration.
- Each grant advances the LFSR STEPS times, then hands the new state to the winner with a one-cycle grant pulse.
- Provides runtime seed load and enable.
- Sits between the shared pseudo-random source and its consumers, such as test-pattern and scrambler blocks.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 4, LFSR width in bits.
- TAPS, 4'b1100, feedback mask. Feedback = XOR of state bits whose mask bit is 1. Shift rule: state <= {state[WIDTH-2:0], fb}.
- SEED, 4'hF, reset and default seed. Must be nonzero.
- STEPS, 1, LFSR shifts per grant (1..15).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  1 = arbitration enabled.
- req  in  NUM_REQ  level request per requester; held until that requester's gnt bit is seen.
- gnt  out  NUM_REQ  one-hot, one-cycle grant pulse.
- rnd_valid  out  1  high exactly in the cycles where gnt is nonzero.
- rnd_data  out  WIDTH  random word for the granted requester; valid while rnd_valid=1.
- gnt_id  out  $clog2(NUM_REQ)  index of the granted requester.
- seed_we  in  1  seed write strobe.
- seed_data  in  WIDTH  seed value.
- lfsr_state  out  WIDTH  current LFSR state.
- busy  out  1  high when the FSM is not in IDLE.
- lockup  out  1  lockup-recovery pulse (optional feature).

Behaviour:
- Reset (async assert, sync release): lfsr_state=SEED, FSM=IDLE, RR pointer=0, cnt=0. gnt, rnd_valid, rnd_data, gnt_id, busy and lockup all 0.
- All outputs are registered.
- FSM states:
  - IDLE: if en=1 and req!=0, latch winner = first set req bit at or after pointer (wrapping modulo NUM_REQ). Set cnt=STEPS-1 and go to ADVANCE. Otherwise stay.
  - ADVANCE: shift LFSR every cycle.
    - cnt!=0: cnt--.
    - cnt==0: on this edge register gnt[winner]=1, rnd_valid=1, rnd_data=shifted state, gnt_id=winner, pointer=(winner+1) mod NUM_REQ. Go to GRANT.
  - GRANT (gnt visible this cycle): on the next edge clear gnt and rnd_valid. rnd_data holds its value.
    - Arbitrate over req with the just-granted bit masked.
    - If en=1 and any req remains: latch new winner and go to ADVANCE.
    - Else: go to IDLE.
- Latency: gnt asserts STEPS cycles after the edge that samples req in IDLE. Sustained throughput is one grant per STEPS+1 cycles.
- en=0 in ADVANCE or GRANT: the in-flight grant completes, then the FSM returns to IDLE. The LFSR never shifts in IDLE.
- seed_we is accepted in any state and overrides the shift in that cycle.
  - Loaded value = seed_data, or SEED if seed_data==0.
  - In ADVANCE, that cycle still counts against cnt.
  - If it coincides with the final ADVANCE cycle, rnd_data = the loaded seed.
- Requester dropping req while not yet granted: it is not granted. The latched winner is still granted (no abort).
- The LFSR never holds all-zero, except by the lockup path described under Optional Feature.
- Asserting rst_n low mid-operation drops any pending grant and restores all reset values immediately.

Optional Feature:
- LFSR_LOCKUP_DET_EN defined:
  - If lfsr_state==0 is detected, the next edge reloads SEED instead of shifting.
  - lockup pulses 1 for one cycle; the FSM and cnt proceed normally.
- Undefined: no detection logic and lockup is tied to 0.

Decomposition:
- Package lfsr_pkg:
  - FSM state enum {IDLE, ADVANCE, GRANT}.
  - Default TAPS/SEED constants for widths 4, 8 and 16.
  - Function next_state(state, taps).
- Sub-module lfsr_core: parameterised shift register with load/shift/hold controls and the lockup detector.
- Arbiter and FSM live in the top module.

Test Plan:
- Reset released, no req → lfsr_state=4'hF; gnt=0, busy=0, rnd_valid=0 indefinitely.
- Only req[0]=1, STEPS=1, repeated five times → rnd_data sequence E, C, 8, 1, 2; gnt=0001 each time; gnt_id=0.
- req=4'b1111 held, pointer 0 → grants to 0, 1, 2, 3, 0 in order, one every 2 cycles, with rnd_data E, C, 8, 1, 2.
- seed_we with seed_data=0 → lfsr_state=F. seed_data=9 during the final ADVANCE cycle → rnd_data=9, and the next grant returns 3.
- 15 consecutive shifts from F → sequence returns to F and never hits 0. Forcing state to 0 with LFSR_LOCKUP_DET_EN → next state F and lockup=1 for one cycle.
- rst_n low mid-ADVANCE with STEPS=4 → gnt never pulses; lfsr_state=F, pointer=0, busy=0 asynchronously.
